// File: rtl/comparator_serial.sv
// Serial magnitude comparator: compares W bits per cycle from the top chunk down,
// stopping at the first differing chunk. Signed or unsigned per transaction, valid/ready on both sides.
module comparator_serial #(
    parameter int N = 32,
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         is_signed,
    output logic         o_valid,
    input  logic         o_ready,
    output logic         lt,
    output logic         eq,
    output logic         gt
);
    localparam int C     = N / W;
    localparam int IDX_W = (C > 1) ? $clog2(C) : 1;
    localparam logic [N-1:0] MSB_MASK = N'(1) << (N - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       a_q, a_d;
    logic [N-1:0]       b_q, b_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               lt_q, lt_d;
    logic               eq_q, eq_d;
    logic               gt_q, gt_d;
    logic [W-1:0]       chunk_a;
    logic [W-1:0]       chunk_b;

    // Signed mode flips the sign bit once at accept time, so every later chunk
    // compare is a plain unsigned one.
    assign chunk_a = W'(a_q >> (idx_q * W));
    assign chunk_b = W'(b_q >> (idx_q * W));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        lt_d    = lt_q;
        eq_d    = eq_q;
        gt_d    = gt_q;
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    a_d     = a ^ (is_signed ? MSB_MASK : '0);
                    b_d     = b ^ (is_signed ? MSB_MASK : '0);
                    idx_d   = IDX_W'(C - 1);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (chunk_a != chunk_b) begin
                    lt_d    = (chunk_a < chunk_b);
                    gt_d    = (chunk_a > chunk_b);
                    eq_d    = 1'b0;
                    state_d = DONE;
                end else if (idx_q == '0) begin
                    lt_d    = 1'b0;
                    gt_d    = 1'b0;
                    eq_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            DONE: begin
                if (o_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            idx_q   <= '0;
            lt_q    <= 1'b0;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            idx_q   <= idx_d;
            lt_q    <= lt_d;
            eq_q    <= eq_d;
            gt_q    <= gt_d;
        end
    end

    assign i_ready = (state_q == IDLE);
    assign o_valid = (state_q == DONE);
    assign lt      = lt_q;
    assign eq      = eq_q;
    assign gt      = gt_q;
endmodule

// File: doc/comparator_serial.md
# comparator_serial

Multi-cycle, parametrised magnitude comparator for two N-bit operands. Signed (two's complement) or unsigned mode is selected per transaction. The block compares W bits per cycle, most-significant chunk first, and stops at the first chunk that differs, so latency depends on the data. It is a registered, handshaked successor to the single-cycle signed less-than comparator and sits between an operand source and a consumer that both use valid/ready.

## Interface
- N, 32: operand width in bits; must be a multiple of W.
- W, 8: chunk width compared per cycle; 1 ≤ W ≤ N.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- i_valid  in  1  operand transaction offered.
- i_ready  out  1  block can accept operands.
- a  in  N  operand A.
- b  in  N  operand B.
- is_signed  in  1  1 = two's-complement compare, 0 = unsigned compare.
- o_valid  out  1  result available.
- o_ready  in  1  consumer accepts result.
- lt  out  1  A < B.
- eq  out  1  A == B.
- gt  out  1  A > B.

## Operation
- Let C = N/W chunks, indexed C-1 (MSB chunk) down to 0.
- States:
  - IDLE: i_ready=1. On i_valid=1, latch a, b and is_signed into internal registers, set idx=C-1 and go to RUN.
  - RUN: i_ready=0. Each cycle, compare chunk idx of the latched A and B as unsigned W-bit values.
    - Signed mode, chunk C-1 only: invert bit N-1 of both operands before comparing. This is equivalent to a two's-complement compare and needs no subtractor or overflow logic.
    - Chunks differ: register lt/gt from this chunk, set eq=0, go to DONE.
    - Chunks equal and idx=0: set eq=1 and lt=gt=0, go to DONE.
    - Otherwise: idx decrements.
  - DONE: o_valid=1, with lt, eq and gt stable. On o_ready=1, go to IDLE.
- Result flags are one-hot whenever o_valid=1. They hold their last value outside DONE and are not meaningful there.
- Operand inputs and is_signed are sampled only on the accept edge. Changes afterwards have no effect on the transaction in flight.
- i_valid while not in IDLE is ignored; i_ready=0 already signals that.
- No same-cycle turnaround: i_ready is 0 in the cycle o_valid&o_ready occurs.
- W=N (C=1) is legal and gives a single RUN cycle.
- Reset, asserted in any state including mid-RUN: go to IDLE and discard the in-flight transaction.
  - Reset values: o_valid=0, lt=0, eq=0, gt=0, idx=0.
  - i_ready=1 from the first cycle after reset deasserts.

## Timing
- Accept edge E0: i_valid&i_ready sampled high.
- First RUN compare edge is E1. If the first differing chunk is the m-th from the top (1 ≤ m ≤ C), or m=C when the operands are equal, DONE is entered at edge Em.
- o_valid rises in the cycle after Em, so latency is m cycles, ranging from 1 to C.
- Throughput: one transaction per m+2 cycles at best (accept cycle, m RUN cycles, one DONE cycle), with o_ready held high.
- Backpressure: o_valid and the flags hold indefinitely while o_ready=0.
- All outputs are registered. There are no combinational paths from inputs to outputs; i_ready is a decode of the state register.

## Test plan
N=32, W=8 (C=4) unless noted. o_ready=1 unless noted.
- Lowest-chunk difference: a=5, b=7, is_signed=1. Required: o_valid 4 cycles after accept, lt=1, eq=0, gt=0.
- Top-chunk difference, both modes: a=0xFFFFFFFF, b=0x00000001.
  - Signed: lt=1 after 1 cycle.
  - Unsigned: gt=1 after 1 cycle.
- Overflow corner: a=0x7FFFFFFF, b=0x80000000.
  - Signed: gt=1.
  - Unsigned: lt=1.
  - Both after 1 cycle.
- Equality: a=b=0x80000000. Required: eq=1, lt=gt=0 after 4 cycles in both modes.
- Backpressure and input isolation: a=3, b=2, hold o_ready=0 for 5 cycles, and drive a=0, b=9 with i_valid=1 during RUN and DONE.
  - o_valid and gt=1 stay stable and i_ready=0 throughout.
  - On o_ready=1, the next cycle shows o_valid=0, i_ready=1.
- Reset and parameter sweep:
  - Assert rst during the 2nd RUN cycle of a=1, b=2. Next cycle: o_valid=0, flags 0, i_ready=1. A following a=2, b=1 returns gt=1.
  - Repeat the random signed/unsigned sweep with W=1 and W=32; each result must match a reference compare, with latency ≤ C.
